dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-ported 16-bit data memory (32K words, combinational read, write on clock edge).
- Port 0: CPU load/store path.
- Port 1: DMA/program-loader path.
- Issues at most one memory access per cycle.
- Registers the memory command and returns read data with a valid strobe.
- CPU has priority; a starvation counter and a DMA burst lock bound DMA wait time.

Parameters:
STARVE_LIMIT, 4, consecutive cycles DMA may be refused before it is forced priority for one grant
BURST_MAX, 8, maximum beats DMA may hold the lock in one burst
AW, 16, address width
DW, 16, data width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
c_req  in  1  CPU request; held until granted
c_we  in  1  CPU write (1) / read (0)
c_addr  in  AW  CPU address
c_wdata  in  DW  CPU write data
c_gnt  out  1  CPU request accepted this cycle (combinational)
c_rvalid  out  1  CPU read data valid
c_rdata  out  DW  CPU read data
d_req  in  1  DMA request
d_we  in  1  DMA write/read
d_lock  in  1  DMA requests burst ownership
d_addr  in  AW  DMA address
d_wdata  in  DW  DMA write data
d_gnt  out  1  DMA request accepted (combinational)
d_rvalid  out  1  DMA read data valid
d_rdata  out  DW  DMA read data
mem_addr  out  AW  memory address (registered)
mem_wrData  out  DW  memory write data (registered)
mem_read  out  1  memory read enable (registered)
mem_write  out  1  memory write enable (registered)
mem_rdData  in  DW  memory read data (combinational from memory)

Behaviour:
- Reset: clock and reset are one clock and a synchronous active-high rst.
  - Values while rst is high and on the first cycle after: state=IDLE, starve_cnt=0, beat_cnt=0; mem_read=mem_write=0; mem_addr=mem_wrData=0; all gnt and rvalid low; rdata=0.
  - Reset mid-operation drops the in-flight command: no write completes and no rvalid is issued for it.
- Pipeline:
  - Cycle N: gnt is decided combinationally from req.
  - End of N: the winner's we/addr/wdata are registered onto mem_*.
  - Cycle N+1: the memory executes the command; a write commits at the end of N+1.
  - End of N+1: mem_rdData is captured for a read.
  - Cycle N+2: the owner's rvalid pulses for 1 cycle with rdata.
  - Read latency is 2 cycles from gnt. Throughput is 1 access/cycle.
  - A cycle with no grant registers mem_read=mem_write=0.
- Grant rules, evaluated in order:
  1. state=DMA_LOCK and d_req → d_gnt.
  2. starve_cnt==STARVE_LIMIT and d_req → d_gnt.
  3. c_req → c_gnt.
  4. d_req → d_gnt.
  - Never both gnt high in the same cycle.
- starve_cnt:
  - Increments when d_req is high and d_gnt is low; saturates at STARVE_LIMIT.
  - Clears on d_gnt or when d_req is low.
- FSM (IDLE, CPU_OWN, DMA_OWN, DMA_LOCK):
  - Next state is CPU_OWN on c_gnt.
  - On d_gnt, next state is DMA_LOCK if d_lock=1, else DMA_OWN.
  - With no grant, next state is IDLE.
  - While in DMA_LOCK:
    - beat_cnt increments per d_gnt.
    - Exit to IDLE (and clear beat_cnt) on d_lock=0, d_req=0, or beat_cnt reaching BURST_MAX-1 on a grant.
    - After a forced exit, CPU wins the next cycle if c_req is high.
    - c_req is stalled, and starve_cnt does not count, during the lock.
- Response routing:
  - The owner tag is pipelined alongside mem_* so rvalid goes to the issuing port only.
  - Writes produce no rvalid.
  - rdata holds its last value when rvalid is low.
- Same-address hazards: none at arbiter level. A read granted the cycle after a write to the same address returns the new data (the write commits before the read's capture edge).
- Address is passed unmodified. Out-of-range addresses are the memory's concern.

Decomposition:
- Shared package dmem_pkg:
  - state encoding localparams: IDLE=2'd0, CPU_OWN=2'd1, DMA_OWN=2'd2, DMA_LOCK=2'd3
  - OWNER_CPU=1'b0, OWNER_DMA=1'b1
  - default AW/DW
- One natural sub-module, dmem_arb_pick: combinational priority/starvation grant logic. Inputs are c_req, d_req, state, starve_cnt; outputs are c_gnt, d_gnt.
- Pipeline registers, counters and FSM stay in the top.

Test Plan:
- CPU only:
  - Stimulus: write 16'hBEEF to 16'h0010, then read 16'h0010.
  - Response: c_gnt each cycle; mem_write=1 one cycle later; c_rvalid=1 with c_rdata=16'hBEEF two cycles after the read grant.
- Contention, STARVE_LIMIT=4:
  - Stimulus: c_req and d_req held high continuously.
  - Response: 4 c_gnt, then 1 d_gnt, repeating; never both grants high.
- DMA burst:
  - Stimulus: d_lock=1, 10 consecutive d_req writes to 16'h0100..16'h0109, with c_req high throughout.
  - Response: 8 consecutive d_gnt (BURST_MAX), then c_gnt, then DMA resumes.
- Write-then-read back-to-back:
  - Stimulus: DMA writes 16'h1234 to 16'h0005 in cycle N; CPU reads 16'h0005 in cycle N+1.
  - Response: c_rdata=16'h1234 with c_rvalid at N+3; d_rvalid never asserted.
- Reset mid-operation:
  - Stimulus: rst asserted the cycle after a DMA write grant.
  - Response: mem_write=0 on the next edge; no rvalid; state=IDLE; post-reset read of that address returns the prior contents.
- Interleaved reads:
  - Stimulus: CPU read of 16'h0000 and DMA read of 16'h0001 in alternating cycles.
  - Response: each rvalid goes only to its issuing port, in issue order, with correct data.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding, owner tags and default widths for the data-memory arbiter
package dmem_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_OWN  = 2'd1,
    DMA_OWN  = 2'd2,
    DMA_LOCK = 2'd3
  } state_t;
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;
  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: ordered grant (lock, starvation, cpu, dma); in c_req d_req state starve_cnt, out c_gnt d_gnt
module dmem_arb_pick import dmem_pkg::*; #(
  parameter int STARVE_LIMIT = 4,
  parameter int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          c_req,
  input  logic          d_req,
  input  logic [1:0]    state,
  input  logic [SW-1:0] starve_cnt,
  output logic          c_gnt,
  output logic          d_gnt
);
  always_comb begin
    d_gnt = d_req && (state == DMA_LOCK || starve_cnt == SW'(STARVE_LIMIT) || !c_req);
    c_gnt = c_req && !d_gnt;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA arbiter and registered command sequencer for one single-port memory; ports clk rst, c_* CPU port, d_* DMA port, mem_* memory side
module dmem_arbiter import dmem_pkg::*; #(
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX = 8,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wrData,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdData
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  state_t state;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] beat_cnt;
  logic pick_c, pick_d, rst_q, owner, rd_q, wr_q, cv_q, dv_q, burst_end, lock_nxt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, c_rdata_q, d_rdata_q;
  dmem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT), .SW(SW)) u_pick (
    .c_req(c_req),
    .d_req(d_req),
    .state(state),
    .starve_cnt(starve_cnt),
    .c_gnt(pick_c),
    .d_gnt(pick_d)
  );
  // no grant during reset or the cycle after; outputs forced to zero while rst is high so an in-flight command never reaches memory
  assign c_gnt = pick_c && !rst && !rst_q;
  assign d_gnt = pick_d && !rst && !rst_q;
  assign mem_read = rd_q && !rst;
  assign mem_write = wr_q && !rst;
  assign mem_addr = rst ? '0 : addr_q;
  assign mem_wrData = rst ? '0 : wdata_q;
  assign c_rvalid = cv_q && !rst;
  assign d_rvalid = dv_q && !rst;
  assign c_rdata = rst ? '0 : c_rdata_q;
  assign d_rdata = rst ? '0 : d_rdata_q;
  // beat_cnt counts grants of the current burst including the entry grant
  assign burst_end = state == DMA_LOCK && beat_cnt == BW'(BURST_MAX - 1);
  assign lock_nxt = d_gnt && d_lock && !burst_end && BURST_MAX > 1;
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state <= IDLE;
      starve_cnt <= '0;
      beat_cnt <= '0;
      owner <= OWNER_CPU;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cv_q <= 1'b0;
      dv_q <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= lock_nxt ? DMA_LOCK : (d_gnt && !burst_end) ? DMA_OWN : c_gnt ? CPU_OWN : IDLE;
      beat_cnt <= lock_nxt ? beat_cnt + 1'b1 : '0;
      starve_cnt <= (d_req && !d_gnt) ? starve_cnt + SW'(starve_cnt != SW'(STARVE_LIMIT)) : '0;
      rd_q <= (c_gnt && !c_we) || (d_gnt && !d_we);
      wr_q <= (c_gnt && c_we) || (d_gnt && d_we);
      if (c_gnt || d_gnt) begin
        addr_q <= d_gnt ? d_addr : c_addr;
        wdata_q <= d_gnt ? d_wdata : c_wdata;
        owner <= d_gnt ? OWNER_DMA : OWNER_CPU;
      end
      cv_q <= rd_q && owner == OWNER_CPU;
      dv_q <= rd_q && owner == OWNER_DMA;
      if (rd_q && owner == OWNER_CPU) c_rdata_q <= mem_rdData;
      if (rd_q && owner == OWNER_DMA) d_rdata_q <= mem_rdData;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed self-checking bench with a behavioural arbiter/memory model
module tb_dmem_arbiter;
  import dmem_pkg::*;
  localparam int SL = 4;
  localparam int BM = 8;
  logic clk = 0, rst = 1;
  logic c_req = 0, c_we = 0, d_req = 0, d_we = 0, d_lock = 0;
  logic [15:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
  logic c_gnt, c_rvalid, d_gnt, d_rvalid, mem_read, mem_write;
  logic [15:0] c_rdata, d_rdata, mem_addr, mem_wrData, mem_rdData;
  logic [15:0] mem [32768];
  logic [15:0] ref_mem [32768];
  typedef struct {bit port; logic [15:0] data; int due;} rd_t;
  rd_t pq[$];
  int total = 0, passed = 0, cyc = 0;
  int refused = 0, beats = 0;
  bit locked = 0, fresh = 0, pr = 0, pw = 0;
  logic [15:0] pa = 0, pd = 0, hold_c = 0, hold_d = 0;
  bit oc, od, ocv, odv, omw;
  logic [15:0] ocd, odd, oma;
  dmem_arbiter #(.STARVE_LIMIT(SL), .BURST_MAX(BM), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wrData(mem_wrData), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdData(mem_rdData)
  );
  always #5 clk = ~clk;
  assign mem_rdData = mem[mem_addr[14:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[14:0]] <= mem_wrData;
  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", n, cyc, got, exp);
  endtask
  task automatic setc(logic r, logic w, logic [15:0] a, logic [15:0] wd);
    c_req = r; c_we = w; c_addr = a; c_wdata = wd;
  endtask
  task automatic setd(logic r, logic w, logic l, logic [15:0] a, logic [15:0] wd);
    d_req = r; d_we = w; d_lock = l; d_addr = a; d_wdata = wd;
  endtask
  // one clock of the reference: sample on negedge, compare, advance the model, then step past posedge
  task automatic step();
    bit gc, gd, ecv, edv;
    rd_t r;
    logic [15:0] a;
    @(negedge clk);
    cyc++;
    oc = c_gnt; od = d_gnt; ocv = c_rvalid; odv = d_rvalid; omw = mem_write;
    ocd = c_rdata; odd = d_rdata; oma = mem_addr;
    if (rst) begin
      chk("rst_ctl", {c_gnt, d_gnt, c_rvalid, d_rvalid, mem_read, mem_write}, 0);
      chk("rst_rdata", {c_rdata, d_rdata}, 0);
      chk("rst_mem", {mem_addr, mem_wrData}, 0);
      refused = 0; locked = 0; beats = 0; pq.delete();
      pr = 0; pw = 0; hold_c = 0; hold_d = 0; fresh = 1;
    end else begin
      if (pw) ref_mem[pa[14:0]] = pd;
      chk("mem_read", mem_read, pr);
      chk("mem_write", mem_write, pw);
      if (pr || pw) chk("mem_addr", mem_addr, pa);
      if (pw) chk("mem_wrData", mem_wrData, pd);
      ecv = 0; edv = 0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        r = pq.pop_front();
        if (r.port) begin edv = 1; hold_d = r.data; end
        else begin ecv = 1; hold_c = r.data; end
      end
      chk("c_rvalid", c_rvalid, ecv);
      chk("d_rvalid", d_rvalid, edv);
      chk("c_rdata", c_rdata, hold_c);
      chk("d_rdata", d_rdata, hold_d);
      gc = 0; gd = 0;
      if (!fresh) begin
        if (locked && d_req) gd = 1;
        else if (refused == SL && d_req) gd = 1;
        else if (c_req) gc = 1;
        else if (d_req) gd = 1;
      end
      chk("c_gnt", c_gnt, gc);
      chk("d_gnt", d_gnt, gd);
      a = gd ? d_addr : c_addr;
      pr = (gc && !c_we) || (gd && !d_we);
      pw = (gc && c_we) || (gd && d_we);
      if (gc || gd) begin pa = a; pd = gd ? d_wdata : c_wdata; end
      if (pr) pq.push_back('{gd, ref_mem[a[14:0]], cyc + 2});
      refused = (d_req && !gd) ? (refused < SL ? refused + 1 : SL) : 0;
      if (gd && d_lock) begin
        beats = locked ? beats + 1 : 1;
        locked = beats < BM;
        if (!locked) beats = 0;
      end else begin
        locked = 0; beats = 0;
      end
      fresh = 0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n, best, run, idx, ncv, ndv, nc;
    int g[60];
    bit dv_any;
    logic [9:0] pat;
    repeat (3) step();
    rst = 0;
    step();
    chk("post_rst_addr", oma, 0);
    chk("post_rst_gnt", {oc, od}, 0);
    for (int i = 0; i < 17; i++) begin
      setc(1, 1, i < 16 ? 16'(i) : 16'h0020, i < 16 ? 16'(16'hA5A5 ^ (i * 16'h0101)) : 16'h5555);
      step();
    end
    setc(1, 1, 16'h0010, 16'hBEEF);
    step();
    chk("cpu_wr_gnt", oc, 1);
    setc(1, 0, 16'h0010, 0);
    step();
    chk("cpu_rd_gnt", oc, 1);
    chk("cpu_mem_write", omw, 1);
    setc(0, 0, 0, 0);
    step();
    step();
    chk("cpu_rvalid", ocv, 1);
    chk("cpu_rdata", ocd, 16'hBEEF);
    setc(1, 0, 16'h0003, 0);
    setd(1, 0, 0, 16'h0007, 0);
    pat = 0; nc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      pat[i] = od;
      nc += int'(oc);
    end
    chk("cont_pattern", pat, 10'h210);
    chk("cont_cpu_count", nc, 8);
    setc(0, 0, 0, 0);
    setd(0, 0, 0, 0, 0);
    repeat (3) step();
    n = 0; best = 0; run = 0;
    for (int k = 0; k < 60; k++) g[k] = 0;
    for (int k = 0; k < 60 && n < 10; k++) begin
      setc(k > 0, 0, 16'h0002, 0);
      setd(1, 1, 1, 16'h0100 + 16'(n), 16'hD000 + 16'(n));
      step();
      g[k] = od ? 2 : oc ? 1 : 0;
      if (od) n++;
      run = od ? run + 1 : 0;
      if (run > best) best = run;
    end
    chk("burst_done", n, 10);
    chk("burst_longest", best, 8);
    idx = 0;
    while (idx < 59 && g[idx] == 2) idx++;
    chk("burst_first_run", idx, 8);
    chk("burst_cpu_after", g[idx], 1);
    setc(0, 0, 0, 0);
    setd(0, 0, 0, 0, 0);
    repeat (3) step();
    dv_any = 0;
    setd(1, 1, 0, 16'h0005, 16'h1234);
    step();
    chk("wtr_dma_gnt", od, 1);
    setd(0, 0, 0, 0, 0);
    setc(1, 0, 16'h0005, 0);
    step();
    chk("wtr_cpu_gnt", oc, 1);
    dv_any |= odv;
    setc(0, 0, 0, 0);
    step();
    dv_any |= odv;
    step();
    dv_any |= odv;
    chk("wtr_rvalid", ocv, 1);
    chk("wtr_rdata", ocd, 16'h1234);
    chk("wtr_no_dvalid", dv_any, 0);
    setd(1, 1, 0, 16'h0020, 16'hDEAD);
    step();
    chk("rmo_gnt", od, 1);
    setd(0, 0, 0, 0, 0);
    rst = 1;
    step();
    chk("rmo_mem_write", omw, 0);
    rst = 0;
    step();
    setc(1, 0, 16'h0020, 0);
    step();
    setc(0, 0, 0, 0);
    step();
    step();
    chk("rmo_rvalid", ocv, 1);
    chk("rmo_prior_data", ocd, 16'h5555);
    ncv = 0; ndv = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8 && i % 2 == 0) setc(1, 0, 16'h0000, 0); else setc(0, 0, 0, 0);
      if (i < 8 && i % 2 == 1) setd(1, 0, 0, 16'h0001, 0); else setd(0, 0, 0, 0, 0);
      step();
      ncv += int'(ocv);
      ndv += int'(odv);
    end
    chk("il_cpu_count", ncv, 4);
    chk("il_dma_count", ndv, 4);
    chk("il_cpu_data", ocd, 16'hA5A5);
    chk("il_dma_data", odd, 16'hA4A4);
    for (int k = 0; k < 3000; k++) begin
      if (!c_req || oc) setc(1'($urandom % 2), 1'($urandom % 2), 16'($urandom_range(0, 16)), 16'($urandom));
      if (!d_req || od) setd(1'($urandom % 3 != 0), 1'($urandom % 2), 1'($urandom % 4 != 0), 16'($urandom_range(0, 16)), 16'($urandom));
      rst = ($urandom % 300) == 0;
      step();
    end
    rst = 0;
    setc(0, 0, 0, 0);
    setd(0, 0, 0, 0, 0);
    repeat (4) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
